// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared segment codes and scan-state encoding for the BCD display driver
package bcd_pkg;

  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;

  typedef enum logic [1:0] {
    UNITS = 2'd0,
    GAP_A = 2'd1,
    TENS  = 2'd2,
    GAP_B = 2'd3
  } scan_state_t;

endpackage

// File: rtl/bcd_to_seg7.sv
// rtl/bcd_to_seg7.sv - combinational BCD digit to active-high 7-segment decoder
module bcd_to_seg7
  import bcd_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] segments
);

  // Codes 10-15 are not BCD digits and show as a dash.
  always_comb begin
    segments = SEG_DASH;
    case (digit)
      4'd0: segments = SEG_0;
      4'd1: segments = SEG_1;
      4'd2: segments = SEG_2;
      4'd3: segments = SEG_3;
      4'd4: segments = SEG_4;
      4'd5: segments = SEG_5;
      4'd6: segments = SEG_6;
      4'd7: segments = SEG_7;
      4'd8: segments = SEG_8;
      4'd9: segments = SEG_9;
      default: segments = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_display_driver.sv
// rtl/bcd_display_driver.sv - latches a BCD result and scans it onto a 2-digit multiplexed 7-segment display
module bcd_display_driver
  import bcd_pkg::*;
#(
  parameter int REFRESH_DIV = 4,
  parameter int GAP_CYCLES  = 1,
  parameter int LZ_BLANK    = 1,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] s_in,
  input  logic       err_in,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic [7:0] held,
  output logic       err
);

  localparam int MAX_DIV = (REFRESH_DIV > GAP_CYCLES) ? REFRESH_DIV : GAP_CYCLES;
  localparam int PW      = $clog2(MAX_DIV);
  localparam logic [PW-1:0] SLOT_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] GAP_LAST  = PW'(GAP_CYCLES - 1);
  localparam logic [6:0]    SEG_INV   = {7{ACTIVE_LOW != 0}};
  localparam logic [1:0]    AN_INV    = {2{ACTIVE_LOW != 0}};

  scan_state_t   state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [PW-1:0] presc_last;
  logic [3:0]    digit;
  logic [6:0]    dec_seg;
  logic [6:0]    seg_d;
  logic [1:0]    an_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      held <= 8'h00;
      err  <= 1'b0;
    end else if (load) begin
      held <= s_in;
      err  <= err_in | (s_in[3:0] > 4'd9) | (s_in[7:4] > 4'd9);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= UNITS;
      presc_q <= '0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    presc_d    = presc_q + 1'b1;
    presc_last = ((state_q == UNITS) || (state_q == TENS)) ? SLOT_LAST : GAP_LAST;
    if (presc_q == presc_last) begin
      state_d = scan_state_t'(state_q + 2'd1);
      presc_d = '0;
    end
  end

  assign digit = (state_q == TENS) ? held[7:4] : held[3:0];

  bcd_to_seg7 u_dec (
    .digit    (digit),
    .segments (dec_seg)
  );

  // An error shows dashes on both digits and keeps the tens digit lit.
  always_comb begin
    seg_d = 7'h00;
    an_d  = 2'b00;
    case (state_q)
      UNITS: begin
        an_d  = 2'b01;
        seg_d = err ? SEG_DASH : dec_seg;
      end
      TENS: begin
        an_d  = ((LZ_BLANK != 0) && (held[7:4] == 4'd0) && !err) ? 2'b00 : 2'b10;
        seg_d = err ? SEG_DASH : dec_seg;
      end
      default: begin
        an_d  = 2'b00;
        seg_d = 7'h00;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      seg <= SEG_INV;
      an  <= AN_INV;
    end else begin
      seg <= seg_d ^ SEG_INV;
      an  <= an_d ^ AN_INV;
    end
  end

endmodule

// File: tb/tb_bcd_display_driver.sv
// tb/tb_bcd_display_driver.sv - randomized self-checking bench for bcd_display_driver against a slot-timing model
module tb_bcd_display_driver;

  localparam int NI = 4;
  localparam int CFG_R  [NI] = '{4, 4, 4, 3};
  localparam int CFG_G  [NI] = '{1, 1, 1, 2};
  localparam int CFG_LZ [NI] = '{1, 0, 1, 1};
  localparam int CFG_AL [NI] = '{0, 0, 1, 0};

  logic       clk;
  logic       reset;
  logic       load;
  logic [7:0] s_in;
  logic       err_in;
  logic [6:0] seg_o  [NI];
  logic [1:0] an_o   [NI];
  logic [7:0] held_o [NI];
  logic       err_o  [NI];

  int tests_run;
  int tests_failed;

  logic [7:0] m_held;
  logic       m_err;
  int         n_edge;
  logic [8:0] exp_out [NI];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  bcd_display_driver #(.REFRESH_DIV(4), .GAP_CYCLES(1), .LZ_BLANK(1), .ACTIVE_LOW(0)) dut_a (
    .clk(clk), .reset(reset), .load(load), .s_in(s_in), .err_in(err_in),
    .seg(seg_o[0]), .an(an_o[0]), .held(held_o[0]), .err(err_o[0]));
  bcd_display_driver #(.REFRESH_DIV(4), .GAP_CYCLES(1), .LZ_BLANK(0), .ACTIVE_LOW(0)) dut_b (
    .clk(clk), .reset(reset), .load(load), .s_in(s_in), .err_in(err_in),
    .seg(seg_o[1]), .an(an_o[1]), .held(held_o[1]), .err(err_o[1]));
  bcd_display_driver #(.REFRESH_DIV(4), .GAP_CYCLES(1), .LZ_BLANK(1), .ACTIVE_LOW(1)) dut_c (
    .clk(clk), .reset(reset), .load(load), .s_in(s_in), .err_in(err_in),
    .seg(seg_o[2]), .an(an_o[2]), .held(held_o[2]), .err(err_o[2]));
  bcd_display_driver #(.REFRESH_DIV(3), .GAP_CYCLES(2), .LZ_BLANK(1), .ACTIVE_LOW(0)) dut_d (
    .clk(clk), .reset(reset), .load(load), .s_in(s_in), .err_in(err_in),
    .seg(seg_o[3]), .an(an_o[3]), .held(held_o[3]), .err(err_o[3]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0: return 7'h3F;  4'd1: return 7'h06;  4'd2: return 7'h5B;  4'd3: return 7'h4F;
      4'd4: return 7'h66;  4'd5: return 7'h6D;  4'd6: return 7'h7D;  4'd7: return 7'h07;
      4'd8: return 7'h7F;  4'd9: return 7'h6F;
      default: return 7'h40;
    endcase
  endfunction

  // Edge n (n>=1 after reset) shows the slot at position (n-1) mod period.
  function automatic logic [8:0] model_out(input int n, input int r, input int g, input int lz,
                                           input int al, input logic [7:0] h, input logic e);
    logic [6:0] s;
    logic [1:0] a;
    int p;
    s = 7'h00;
    a = 2'b00;
    if (n > 0) begin
      p = (n - 1) % (2 * r + 2 * g);
      if (p < r) begin
        a = 2'b01;
        s = e ? 7'h40 : seg_code(h[3:0]);
      end else if (p >= r + g && p < 2 * r + g) begin
        a = (lz != 0 && h[7:4] == 4'd0 && !e) ? 2'b00 : 2'b10;
        s = e ? 7'h40 : seg_code(h[7:4]);
      end
    end
    if (al != 0) begin
      s = ~s;
      a = ~a;
    end
    return {a, s};
  endfunction

  task automatic step(input logic r, input logic l, input logic [7:0] s, input logic e);
    reset  = r;
    load   = l;
    s_in   = s;
    err_in = e;
    @(posedge clk);
    n_edge = r ? 0 : n_edge + 1;
    for (int i = 0; i < NI; i++)
      exp_out[i] = model_out(n_edge, CFG_R[i], CFG_G[i], CFG_LZ[i], CFG_AL[i], m_held, m_err);
    if (r) begin
      m_held = 8'h00;
      m_err  = 1'b0;
    end else if (l) begin
      m_held = s;
      m_err  = e | (s[3:0] > 4'd9) | (s[7:4] > 4'd9);
    end
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      check($sformatf("seg[%0d] n=%0d", i, n_edge), {25'd0, seg_o[i]}, {25'd0, exp_out[i][6:0]});
      check($sformatf("an[%0d] n=%0d", i, n_edge), {30'd0, an_o[i]}, {30'd0, exp_out[i][8:7]});
      check($sformatf("held[%0d] n=%0d", i, n_edge), {24'd0, held_o[i]}, {24'd0, m_held});
      check($sformatf("err[%0d] n=%0d", i, n_edge), {31'd0, err_o[i]}, {31'd0, m_err});
    end
  endtask

  task automatic idle(input int cycles);
    for (int k = 0; k < cycles; k++) step(1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    m_held       = 8'h00;
    m_err        = 1'b0;
    n_edge       = 0;
    reset        = 1'b1;
    load         = 1'b0;
    s_in         = 8'h00;
    err_in       = 1'b0;

    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b1, 8'h47, 1'b0);
    idle(21);
    step(1'b0, 1'b1, 8'h05, 1'b0);
    idle(20);
    step(1'b0, 1'b1, 8'h3A, 1'b0);
    idle(12);
    step(1'b0, 1'b1, 8'h12, 1'b1);
    idle(12);
    step(1'b0, 1'b1, 8'h18, 1'b0);
    idle(10);
    step(1'b0, 1'b1, 8'h0B, 1'b0);
    idle(12);
    step(1'b1, 1'b1, 8'h99, 1'b0);
    step(1'b0, 1'b1, 8'h63, 1'b0);
    idle(6);
    // Mid tens-slot loads, back to back.
    step(1'b0, 1'b1, 8'h81, 1'b0);
    step(1'b0, 1'b1, 8'h29, 1'b0);
    idle(10);

    for (int k = 0; k < 600; k++) begin
      logic       r;
      logic       l;
      logic [7:0] s;
      logic       e;
      r = ($urandom_range(0, 63) == 0);
      l = ($urandom_range(0, 7) == 0);
      s = ($urandom_range(0, 3) == 0) ? 8'($urandom) : {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      if ($urandom_range(0, 3) == 0) s[7:4] = 4'd0;
      e = ($urandom_range(0, 9) == 0);
      step(r, l, s, e);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
